// File: rtl/reg_bank_sched_pkg.sv
// reg_bank_sched_pkg: shared types, constants and one-hot helper for the register-bank write scheduler
package reg_bank_sched_pkg;
  typedef enum logic {IDLE, CLEAR} sched_state_t;
  localparam int GCNT_W = 16;
  localparam int OH_W = 256;
  function automatic logic [OH_W-1:0] onehot(input int idx);
    onehot = OH_W'(1) << idx;
  endfunction
endpackage

// File: rtl/reg_bank_sched_rr_arbiter.sv
// rr_arbiter: rotating-priority arbiter, first request at or after ptr_i wins
module rr_arbiter
  import reg_bank_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);
  logic [NREQ-1:0] rot;
  assign rot = NREQ'({req_i, req_i} >> ptr_i);
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_o = 1'b1;
        idx_o = PW'((int'(ptr_i) + k) % NREQ);
      end
    end
    gnt_o = any_o ? NREQ'(onehot(int'(idx_o))) : '0;
  end
endmodule

// File: rtl/reg_bank_sched.sv
// reg_bank_sched: round-robin write scheduler and sequenced clear for a register bank
// Define REG_BANK_SCHED_GRANT_CNT_EN to add per-requester saturating grant counters (grant_cnt_o).
module reg_bank_sched
  import reg_bank_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NREG = 8,
  parameter int WL = 16,
  localparam int AW = $clog2(NREG),
  localparam int PW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  input  logic [NREQ*WL-1:0]   req_data_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic                 clr_start_i,
  output logic                 clr_busy_o,
  output logic                 clr_done_o,
  output logic [NREG-1:0]      reg_wen_o,
  output logic [WL-1:0]        reg_d_o
`ifdef REG_BANK_SCHED_GRANT_CNT_EN
  ,
  output logic [NREQ*GCNT_W-1:0] grant_cnt_o
`endif
);
  sched_state_t    state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREG-1:0] wen_q, wen_d;
  logic [WL-1:0]   d_q, d_d;
  logic            done_q, done_d;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gidx;
  logic            any;
  logic            arb_en;
  logic [AW-1:0]   addr_sel;
  logic [WL-1:0]   data_sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i(req_valid_i),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gidx),
    .any_o(any)
  );

  // a pending clear start takes the write path away from requesters
  assign arb_en      = (state_q == IDLE) && !clr_start_i && !rst;
  assign req_ready_o = arb_en ? gnt : '0;
  assign addr_sel    = req_addr_i[int'(gidx)*AW +: AW];
  assign data_sel    = req_data_i[int'(gidx)*WL +: WL];
  assign clr_busy_o  = (state_q == CLEAR);
  assign clr_done_o  = done_q;
  assign reg_wen_o   = clr_busy_o ? NREG'(onehot(int'(cnt_q))) : wen_q;
  assign reg_d_o     = clr_busy_o ? '0 : d_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    wen_d   = '0;
    d_d     = d_q;
    done_d  = 1'b0;
    if (state_q == CLEAR) begin
      state_d = (cnt_q == AW'(NREG - 1)) ? IDLE : CLEAR;
      done_d  = (cnt_q == AW'(NREG - 1));
      cnt_d   = (cnt_q == AW'(NREG - 1)) ? '0 : cnt_q + 1'b1;
    end else if (clr_start_i) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end else if (any) begin
      ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      wen_d = NREG'(onehot(int'(addr_sel)));
      d_d   = data_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      wen_q   <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      d_q     <= d_d;
      done_q  <= done_d;
    end
  end

`ifdef REG_BANK_SCHED_GRANT_CNT_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    logic [GCNT_W-1:0] gc_q;
    always_ff @(posedge clk)
      gc_q <= rst ? '0 : gc_q + GCNT_W'(req_ready_o[g] && gc_q != '1);
    assign grant_cnt_o[g*GCNT_W +: GCNT_W] = gc_q;
  end
`endif
endmodule

// File: tb/tb_reg_bank_sched.sv
// tb_reg_bank_sched: directed self-checking bench for reg_bank_sched (NREG=8 main instance, NREG=6 for out-of-range)
module tb_reg_bank_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  valid = '0, ready;
  logic [11:0] addr = '0;
  logic [63:0] data = '0;
  logic        clr_start = 1'b0, busy, done;
  logic [7:0]  wen;
  logic [15:0] d;

  logic [3:0]  valid6 = '0, ready6;
  logic [11:0] addr6 = '0;
  logic [63:0] data6 = '0;
  logic        busy6, done6;
  logic [5:0]  wen6;
  logic [15:0] d6;
`ifdef REG_BANK_SCHED_GRANT_CNT_EN
  logic [63:0] gcnt, gcnt6;
`endif

  int checks = 0;
  int failures = 0;

  reg_bank_sched #(.NREQ(4), .NREG(8), .WL(16)) dut (
    .clk(clk), .rst(rst), .req_valid_i(valid), .req_addr_i(addr), .req_data_i(data),
    .req_ready_o(ready), .clr_start_i(clr_start), .clr_busy_o(busy), .clr_done_o(done),
    .reg_wen_o(wen), .reg_d_o(d)
`ifdef REG_BANK_SCHED_GRANT_CNT_EN
    , .grant_cnt_o(gcnt)
`endif
  );

  reg_bank_sched #(.NREQ(4), .NREG(6), .WL(16)) dut6 (
    .clk(clk), .rst(rst), .req_valid_i(valid6), .req_addr_i(addr6), .req_data_i(data6),
    .req_ready_o(ready6), .clr_start_i(1'b0), .clr_busy_o(busy6), .clr_done_o(done6),
    .reg_wen_o(wen6), .reg_d_o(d6)
`ifdef REG_BANK_SCHED_GRANT_CNT_EN
    , .grant_cnt_o(gcnt6)
`endif
  );

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; valid = '0; valid6 = '0; clr_start = 1'b0;
    repeat (2) next();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 4'hF; clr_start = 1'b0;
    next();
    @(negedge clk);
    checks++; if (ready !== 4'h0) begin failures++; $display("FAIL reset_ready: got %h expected %h", ready, 4'h0); end
    checks++; if (wen !== 8'h00) begin failures++; $display("FAIL reset_wen: got %h expected %h", wen, 8'h00); end
    checks++; if (d !== 16'h0) begin failures++; $display("FAIL reset_d: got %h expected %h", d, 16'h0); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_clr: got busy=%b done=%b expected 0 0", busy, done); end
    next();
    rst = 1'b0; valid = '0;
  endtask

  task automatic test_single;
    valid = 4'b0010; addr = 12'd3 << 3; data = 64'hABCD << 16;
    @(negedge clk);
    checks++; if (ready !== 4'b0010) begin failures++; $display("FAIL single_ready: got %b expected %b", ready, 4'b0010); end
    next();
    valid = '0;
    @(negedge clk);
    checks++; if (wen !== 8'h08) begin failures++; $display("FAIL single_wen: got %h expected %h", wen, 8'h08); end
    checks++; if (d !== 16'hABCD) begin failures++; $display("FAIL single_d: got %h expected %h", d, 16'hABCD); end
    next();
    valid = 4'hF;
    @(negedge clk);
    checks++; if (ready !== 4'b0100) begin failures++; $display("FAIL single_ptr: got %b expected %b", ready, 4'b0100); end
    next();
    valid = '0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    valid = 4'hF;
    addr = {3'd7, 3'd6, 3'd5, 3'd4};
    data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (ready !== 4'(1 << (k % 4))) begin failures++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, ready, 4'(1 << (k % 4))); end
      if (k > 0) begin
        checks++; if (wen !== 8'(1 << (4 + (k - 1) % 4))) begin failures++; $display("FAIL b2b_wen[%0d]: got %h expected %h", k, wen, 8'(1 << (4 + (k - 1) % 4))); end
        checks++; if (d !== 16'(16'h1111 * ((k - 1) % 4 + 1))) begin failures++; $display("FAIL b2b_d[%0d]: got %h expected %h", k, d, 16'(16'h1111 * ((k - 1) % 4 + 1))); end
      end
      next();
    end
    valid = '0;
    @(negedge clk);
    checks++; if (wen !== 8'h10 || d !== 16'h1111) begin failures++; $display("FAIL b2b_last: got wen=%h d=%h expected 10 1111", wen, d); end
    next();
  endtask

  task automatic test_clear;
    valid = 4'hF; clr_start = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 4'h0 || busy !== 1'b0) begin failures++; $display("FAIL clr_start_cycle: got ready=%b busy=%b expected 0000 0", ready, busy); end
    next();
    for (int k = 0; k < 8; k++) begin
      clr_start = (k == 3);
      @(negedge clk);
      checks++; if (busy !== 1'b1 || ready !== 4'h0 || done !== 1'b0) begin failures++; $display("FAIL clr_busy[%0d]: got busy=%b ready=%b done=%b expected 1 0000 0", k, busy, ready, done); end
      checks++; if (wen !== 8'(1 << k) || d !== 16'h0) begin failures++; $display("FAIL clr_wen[%0d]: got wen=%h d=%h expected %h 0000", k, wen, d, 8'(1 << k)); end
      next();
    end
    clr_start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL clr_done: got busy=%b done=%b expected 0 1", busy, done); end
    checks++; if (ready !== 4'b0010 || wen !== 8'h00) begin failures++; $display("FAIL clr_resume: got ready=%b wen=%h expected 0010 00", ready, wen); end
    next();
    valid = '0;
    @(negedge clk);
    checks++; if (wen !== 8'h20 || d !== 16'h2222 || done !== 1'b0) begin failures++; $display("FAIL clr_post_write: got wen=%h d=%h done=%b expected 20 2222 0", wen, d, done); end
    next();
  endtask

  task automatic test_reset_mid_clear;
    valid = '0; clr_start = 1'b1;
    next();
    clr_start = 1'b0;
    repeat (3) next();
    rst = 1'b1; valid = 4'hF;
    @(negedge clk);
    checks++; if (wen !== 8'h08 || ready !== 4'h0) begin failures++; $display("FAIL mid_clr_rst_cycle: got wen=%h ready=%b expected 08 0000", wen, ready); end
    next();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (wen !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mid_clr_after_rst: got wen=%h busy=%b done=%b expected 00 0 0", wen, busy, done); end
    checks++; if (ready !== 4'b0001) begin failures++; $display("FAIL mid_clr_ptr: got %b expected %b", ready, 4'b0001); end
    next();
    valid = '0;
    @(negedge clk);
    checks++; if (wen !== 8'h10 || d !== 16'h1111) begin failures++; $display("FAIL mid_clr_write: got wen=%h d=%h expected 10 1111", wen, d); end
    next();
    clr_start = 1'b1;
    next();
    clr_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b1 || wen !== 8'(1 << k)) begin failures++; $display("FAIL reclr_wen[%0d]: got busy=%b wen=%h expected 1 %h", k, busy, wen, 8'(1 << k)); end
      next();
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL reclr_done: got busy=%b done=%b expected 0 1", busy, done); end
    next();
  endtask

  task automatic test_out_of_range;
    do_reset();
    valid6 = 4'b0001; addr6 = 12'd7; data6 = 64'hBEEF;
    @(negedge clk);
    checks++; if (ready6 !== 4'b0001) begin failures++; $display("FAIL oor_ready: got %b expected %b", ready6, 4'b0001); end
    next();
    valid6 = 4'b0011; addr6 = 12'd7 | (12'd5 << 3); data6 = 64'hBEEF | (64'h5555 << 16);
    @(negedge clk);
    checks++; if (wen6 !== 6'b0) begin failures++; $display("FAIL oor_dropped: got %b expected %b", wen6, 6'b0); end
    checks++; if (ready6 !== 4'b0010) begin failures++; $display("FAIL oor_ptr: got %b expected %b", ready6, 4'b0010); end
    next();
    valid6 = '0;
    @(negedge clk);
    checks++; if (wen6 !== 6'b100000 || d6 !== 16'h5555) begin failures++; $display("FAIL oor_next_write: got wen=%b d=%h expected 100000 5555", wen6, d6); end
    next();
  endtask

`ifdef REG_BANK_SCHED_GRANT_CNT_EN
  task automatic test_grant_cnt;
    do_reset();
    valid = 4'b0100;
    repeat (70000) next();
    valid = '0;
    @(negedge clk);
    checks++; if (gcnt[47:32] !== 16'hFFFF) begin failures++; $display("FAIL gcnt_sat: got %h expected %h", gcnt[47:32], 16'hFFFF); end
    checks++; if (gcnt[31:0] !== 32'h0 || gcnt[63:48] !== 16'h0) begin failures++; $display("FAIL gcnt_others: got %h expected 0000ffff00000000", gcnt); end
    next();
    clr_start = 1'b1;
    next();
    clr_start = 1'b0;
    repeat (10) next();
    @(negedge clk);
    checks++; if (gcnt[47:32] !== 16'hFFFF) begin failures++; $display("FAIL gcnt_after_clear: got %h expected %h", gcnt[47:32], 16'hFFFF); end
    next();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    test_out_of_range();
`ifdef REG_BANK_SCHED_GRANT_CNT_EN
    test_grant_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_bank_sched.md
Name: reg_bank_sched

Overview:
- Write scheduler for a bank of NREG single-word registers holding accelerator state (Q-values, weights).
- Shares the bank's single write path among NREQ requesters using round-robin arbitration.
- Drives the per-register write enables and a shared data bus.
- Provides a sequenced bank-clear operation that zeroes every register, one per cycle.

Parameters:
- NREQ, 4, number of write requesters (≥2)
- NREG, 8, number of registers in the bank (≥2)
- WL, 16, register data width
- AW, $clog2(NREG), register address width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  per-requester target register index; slice i = requester i
- req_data  in  NREQ*WL  per-requester write data; slice i = requester i
- req_ready  out  NREQ  one-hot grant, same cycle as acceptance
- clr_start  in  1  start bank clear (single-cycle pulse)
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the last register is cleared
- reg_wen  out  NREG  one-hot write enable to the bank
- reg_d  out  WL  shared write data to the bank

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - All registered outputs are 0.
  - RR pointer = 0; state = IDLE; clear counter = 0.
  - req_ready is forced to 0 while rst is high.
- FSM states: IDLE, CLEAR.
  - IDLE → CLEAR when clr_start=1.
  - CLEAR → IDLE after address NREG-1 is issued.
- IDLE arbitration:
  - req_ready is combinational from req_valid and the pointer.
  - Grant goes to the first valid requester at or after the pointer, wrapping modulo NREQ.
  - Handshake: a transfer occurs when req_valid[i] & req_ready[i].
  - A requester holds valid, addr and data stable until it is granted.
  - On a transfer by requester i:
    - pointer ← (i+1) mod NREQ.
    - Next cycle: reg_wen = onehot(req_addr[i]), reg_d = req_data[i].
    - The register captures the data at the end of that cycle, so q reflects the write 2 cycles after acceptance.
  - No valid requests: pointer unchanged; reg_wen = 0.
  - At most one write per cycle, so back-to-back grants give a throughput of 1 write/cycle.
- Out-of-range addresses (req_addr ≥ NREG):
  - The request is accepted (ready asserted) and the pointer advances.
  - reg_wen stays all-0: the write is dropped.
- Clear:
  - If clr_start=1 in IDLE, clear has priority: req_ready = 0 in that cycle.
  - The next cycle enters CLEAR with clr_busy=1.
  - In CLEAR: reg_wen = onehot(cnt), reg_d = 0, cnt increments 0..NREG-1, one register per cycle.
  - req_ready = 0 throughout CLEAR.
  - clr_done pulses in the cycle after the cnt=NREG-1 write, as clr_busy drops.
  - Arbitration resumes in that same cycle, with the pointer preserved from before the clear.
  - clr_start while in CLEAR is ignored and does not restart the sequence.
- Reset mid-clear or mid-write: any pending write is cancelled (reg_wen=0 next cycle); FSM returns to IDLE.
- reg_d holds its last value when reg_wen=0; downstream logic must not rely on it.

Optional Feature:
- Macro REG_BANK_SCHED_GRANT_CNT_EN.
- Defined:
  - Adds output port grant_cnt, NREQ*16 bits.
  - One 16-bit saturating counter per requester, incremented on each of that requester's transfers.
  - Counters stick at 0xFFFF; reset to 0 on rst.
  - The bank clear does not reset the counters.
- Undefined:
  - Port and counters are absent.
  - All other behaviour is identical.

Decomposition:
- Package reg_bank_sched_pkg:
  - State enum sched_state_t {IDLE, CLEAR}.
  - Counter width constant GCNT_W=16.
  - Helper function onehot encode.
- Sub-module rr_arbiter, parameterised by NREQ:
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any_grant.
  - Pointer update stays in the parent.

Test Plan:
- Single requester: req_valid=0010, addr[1]=3, data[1]=0xABCD → req_ready=0010 same cycle; next cycle reg_wen=0x08, reg_d=0xABCD; pointer=2.
- All four valid continuously with pointer=0 → grants in order 0,1,2,3,0 on consecutive cycles; reg_wen follows one cycle later each time.
- clr_start with all requests valid → req_ready=0 that cycle; clr_busy for 8 cycles; reg_wen walks 0x01..0x80 with reg_d=0; clr_done pulse; grants then resume at the preserved pointer.
- Out-of-range: NREG=6, addr=7 → ready asserted, pointer advances, reg_wen stays 0.
- rst asserted on the 4th cycle of a clear → next cycle reg_wen=0, clr_busy=0, state IDLE, pointer=0; a later clr_start runs the full clear again.
- With REG_BANK_SCHED_GRANT_CNT_EN: 70000 grants to requester 2 → grant_cnt[2]=0xFFFF, other counters unaffected.
